// File: rtl/appr_mult_stream.sv
// -----------------------------------------------------------------------------
// appr_mult_stream
//
// Streaming approximate unsigned multiplier. Each accepted operand pair goes
// through four steps:
//   1. Normalise: each operand is shifted left until its MSB is 1, and the
//      number of shifts is counted (za, zb).
//   2. Multiply: the top K bits of the two normalised operands are multiplied
//      by a shift-add unit that handles one multiplier bit per cycle.
//   3. Scale: the product is shifted back by 2*(WIDTH-K) - (za+zb).
//   4. Output: the result is held until the sink accepts it.
// K is KEEP by default. When exact_mode is set for the transaction, K is WIDTH
// and the product is exact.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset; it aborts any transaction
//   in_valid    operand pair valid
//   in_ready    high only in IDLE; one transaction is in flight at a time
//   a, b        unsigned operands, WIDTH bits each
//   exact_mode  latched when a pair is accepted; 1 = exact product
//   out_valid   result valid; stays high until out_ready
//   out_ready   the sink accepts the result
//   result      product, 2*WIDTH bits; stable while out_valid is high
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module appr_mult_stream #(
    parameter int WIDTH = 16,
    parameter int KEEP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               exact_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int RW = 2 * WIDTH;            // product width
    localparam int CW = $clog2(WIDTH + 1);    // holds 0..WIDTH
    localparam int ZW = $clog2(WIDTH) + 1;    // zero count, at most WIDTH-1
    localparam int EW = $clog2(2 * WIDTH) + 2; // signed scale exponent

    generate
        if (KEEP < 2 || KEEP > WIDTH) begin : g_bad_keep
            $error("appr_mult_stream: KEEP must lie in 2..WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        MUL   = 3'd2,
        SCALE = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     norm_a, norm_b;   // operands being normalised
    logic [ZW-1:0]        za, zb;           // leading-zero shift counts
    logic                 exact_q;          // latched exact_mode
    logic [RW-1:0]        mcand;            // multiplicand, moves left each step
    logic [WIDTH-1:0]     mplier;           // multiplier, moves right each step
    logic [RW-1:0]        acc;              // shift-add partial product
    logic [CW-1:0]        cnt;              // count of MUL cycles done
    logic [RW-1:0]        result_q;

    logic                 zero_in;
    logic [CW-1:0]        k_eff;
    logic [CW-1:0]        drop;
    logic                 mul_last;
    logic [EW-1:0]        two_drop;
    logic [EW-1:0]        zsum;
    logic signed [EW-1:0] e_val;

    // Shift the raw product back by e. A negative e means a right shift,
    // which truncates toward zero. A left shift cannot overflow, because the
    // rescaled value is never above the exact product.
    function automatic logic [RW-1:0] scale_product(input logic [RW-1:0]        p,
                                                    input logic signed [EW-1:0] e);
        logic [EW-1:0] mag;
        mag = e[EW-1] ? EW'(-e) : EW'(e);
        if (e[EW-1])
            scale_product = p >> mag;
        else
            scale_product = p << mag;
    endfunction

    assign zero_in  = (a == '0) || (b == '0);
    assign k_eff    = exact_q ? CW'(WIDTH) : CW'(KEEP);
    assign drop     = CW'(WIDTH) - k_eff;
    assign mul_last = (cnt == (k_eff - CW'(1)));

    // e = 2*(WIDTH-K) - (za+zb)
    assign two_drop = EW'(drop) << 1;
    assign zsum     = EW'(za) + EW'(zb);
    assign e_val    = signed'(two_drop - zsum);

    assign result   = result_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_nxt = zero_in ? OUT : NORM;
            end
            NORM: begin
                // Both MSBs must already be set when they are tested. A shift
                // in this cycle delays the move to MUL by one cycle.
                if (norm_a[WIDTH-1] && norm_b[WIDTH-1])
                    state_nxt = MUL;
            end
            MUL: begin
                if (mul_last)
                    state_nxt = SCALE;
            end
            SCALE: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            norm_a   <= '0;
            norm_b   <= '0;
            za       <= '0;
            zb       <= '0;
            exact_q  <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        norm_a  <= a;
                        norm_b  <= b;
                        exact_q <= exact_mode;
                        za      <= '0;
                        zb      <= '0;
                        if (zero_in)
                            result_q <= '0;
                    end
                end
                NORM: begin
                    if (!norm_a[WIDTH-1]) begin
                        norm_a <= norm_a << 1;
                        za     <= za + ZW'(1);
                    end
                    if (!norm_b[WIDTH-1]) begin
                        norm_b <= norm_b << 1;
                        zb     <= zb + ZW'(1);
                    end
                    if (norm_a[WIDTH-1] && norm_b[WIDTH-1]) begin
                        // Keep only the top K bits of each normalised operand.
                        mcand  <= RW'(norm_a >> drop);
                        mplier <= norm_b >> drop;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    // Use one multiplier bit per cycle, LSB first. After K
                    // cycles every kept bit has been used.
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                SCALE: begin
                    result_q <= scale_product(acc, e_val);
                end
                default: begin
                    // In OUT, every register holds its value so that result
                    // stays stable while the sink stalls.
                end
            endcase
        end
    end

endmodule

// File: doc/appr_mult_stream.md
Name: appr_mult_stream

Overview:
- Parametrised, streaming successor to the file-driven approximate multiplier.
- Accepts unsigned operand pairs over a valid/ready handshake and normalises each operand with an iterative leading-zero shift.
- Multiplies the top KEEP bits of both operands with a sequential shift-add unit, then rescales the product.
- Adds a per-transaction exact mode and output backpressure, so it can sit between a stimulus source and a result sink with no file I/O.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH bits.
- KEEP, 8, significant bits kept per operand after normalisation; legal range 2..WIDTH, enforced with an elaboration-time check.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- exact_mode  input  1  latched on accept; 1 = keep all WIDTH bits, giving an exact product.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- result  output  2*WIDTH  product.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, result=0, busy=0.
  - All internal registers are cleared.
  - Reset during any state aborts the transaction; the in-flight result is discarded and never presented.
- Effective keep width: K = WIDTH if the latched exact_mode=1, else KEEP.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b and exact_mode, and clear the zero counts za and zb.
    - If a==0 or b==0, go to OUT with result 0.
    - Otherwise go to NORM.
  - NORM: evaluated once per cycle.
    - Each operand whose MSB is 0 shifts left 1 and increments its zero count.
    - When both MSBs are 1 at the evaluation, go to MUL.
    - Duration is max(za,zb)+1 cycles.
  - MUL:
    - ta = normalised A[WIDTH-1 : WIDTH-K]; tb likewise for B.
    - p = ta*tb (2*K bits), computed by shift-add over exactly K cycles, one multiplier bit per cycle, LSB first.
    - Then go to SCALE.
  - SCALE: 1 cycle.
    - e = 2*(WIDTH-K) - (za+zb).
    - result = p << e if e >= 0, else p >> (-e). Bits shifted out are truncated toward zero.
    - Then go to OUT.
  - OUT: out_valid=1, and result is held stable. On out_ready, go to IDLE with out_valid=0 the next cycle.
- Latency, from the accept edge to out_valid high:
  - Nonzero operands: max(za,zb) + K + 2 cycles.
  - Zero operand: 1 cycle.
- Handshake rules:
  - in_ready is 1 only in IDLE, so there is one transaction in flight.
  - in_valid outside IDLE is ignored.
  - a, b and exact_mode may change freely after the accept edge.
  - out_valid never drops without out_ready; result must not change while out_valid=1.
  - A new accept is possible at earliest the cycle after the OUT->IDLE transition, giving a 1-cycle bubble.
- Accuracy:
  - The result is exact whenever both operands are below 2^K, or exact_mode=1.
  - Otherwise result ≤ the exact product; no overflow is possible.

Test Plan (WIDTH=16, KEEP=8):
1. Small operands:
   - Stimulus: a=13, b=11, exact_mode=0.
   - Required: result=143 (exact). out_valid rises 22 cycles after accept (za=zb=12, max+8+2).
2. Full-scale truncation:
   - Stimulus: a=0xFFFF, b=0xFFFF, exact_mode=0.
   - Required: result=0xFE010000, latency 10.
   - Repeat with exact_mode=1: result=0xFFFE0001, latency 18.
3. Mixed normalisation:
   - Stimulus: a=0x1234, b=0x0100.
   - Required: za=3, zb=7, p=145*128=18560, e=6, result=0x00122000 (exact would be 0x00123400), latency 17.
4. Zero operand:
   - Stimulus: a=0, b=1234.
   - Required: result=0, out_valid 1 cycle after accept; the NORM, MUL and SCALE states are skipped.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles while a result is valid, and pulse in_valid with new operands during the stall.
   - Required: out_valid and result stay stable, in_ready=0, and the new operands are not accepted.
   - After out_ready=1, the block returns to IDLE and accepts the next pair.
6. Reset mid-operation:
   - Stimulus: assert rst for 1 cycle during MUL.
   - Required: the next cycle shows in_ready=1, out_valid=0, result=0, busy=0, and no stale result appears.
   - A subsequent transaction a=3, b=5 gives result=15.
